// File: rtl/bus_bridge_pkg.sv
// Shared types and byte codes for the serial-to-CPU-bus bridge.
// Holds the FSM state encodings and command/reply constants.
package bus_bridge_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR_H,
      ADDR_L,
      LEN,
      WR_DATA,
      BUS_WAIT,
      BUS_ACC,
      RD_DATA,
      TX_BYTE,
      TX_ACK
   } state_t;

   typedef enum logic [1:0] {
      A_IDLE,
      A_WAIT,
      A_RD2
   } acc_t;

   localparam logic [7:0] CMD_W   = 8'h57;
   localparam logic [7:0] CMD_R   = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h2E;
   localparam logic [7:0] RSP_ERR = 8'h3F;
   localparam logic [7:0] RSP_TMO = 8'h21;

   // A length byte of zero encodes a full 256-byte burst.
   function automatic logic [8:0] len_count(input logic [7:0] len);
      return (len == 8'd0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/bus_bridge_access.sv
// One CPU-bus access: request/grant, 1-cycle write strobe or 2-cycle read.
// Losing the grant mid-read restarts the access from its first cycle.
module bus_bridge_access
   import bus_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        done,
   output logic [7:0]  rdata,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] address,
   output logic [7:0]  dout,
   input  logic [7:0]  din,
   output logic        read
);

   acc_t state;
   acc_t state_nxt;
   logic drive;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= A_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      unique case (state)
         A_IDLE: begin
            if (start) state_nxt = A_WAIT;
         end
         A_WAIT: begin
            if (bus_gnt) begin
               if (we) begin
                  done      = 1'b1;
                  state_nxt = A_IDLE;
               end else begin
                  state_nxt = A_RD2;
               end
            end
         end
         A_RD2: begin
            if (bus_gnt) begin
               done      = 1'b1;
               state_nxt = A_IDLE;
            end else begin
               state_nxt = A_WAIT;
            end
         end
         default: state_nxt = A_IDLE;
      endcase
   end

   assign drive   = bus_gnt && (state != A_IDLE);
   assign bus_req = (state != A_IDLE);
   assign address = drive ? addr : 16'h0000;
   assign dout    = (drive && we) ? wdata : 8'h00;
   assign read    = !(drive && we);
   // RAM data is valid at the end of the second read cycle.
   assign rdata   = din;

endmodule

// File: rtl/bus_bridge.sv
// Serial command parser acting as a second CPU-bus initiator.
// Optional inter-byte timeout: define BUS_BRIDGE_TIMEOUT_EN.
module bus_bridge
   import bus_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 26600000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] address,
   output logic [7:0]  dout,
   input  logic [7:0]  din,
   output logic        read,
   output logic        busy
);

   state_t      state, state_nxt;
   logic [7:0]  cmd, cmd_nxt;
   logic [15:0] addr, addr_nxt;
   logic [8:0]  cnt, cnt_nxt;
   logic [7:0]  wdata, wdata_nxt;
   logic [7:0]  tx_data_nxt;
   logic        start, start_nxt;
   logic        we;
   logic        done;
   logic [7:0]  rdata;
   logic        accept;
   logic        tmo;

   assign we       = (cmd == CMD_W);
   assign rx_ready = !rst && (state inside {IDLE, ADDR_H, ADDR_L, LEN, WR_DATA});
   assign accept   = rx_valid && rx_ready;
   assign tx_valid = (state == TX_BYTE) || (state == TX_ACK);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cmd     <= 8'h00;
         addr    <= 16'h0000;
         cnt     <= 9'd0;
         wdata   <= 8'h00;
         tx_data <= 8'h00;
         start   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cmd     <= cmd_nxt;
         addr    <= addr_nxt;
         cnt     <= cnt_nxt;
         wdata   <= wdata_nxt;
         tx_data <= tx_data_nxt;
         start   <= start_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_nxt     = cmd;
      addr_nxt    = addr;
      cnt_nxt     = cnt;
      wdata_nxt   = wdata;
      tx_data_nxt = tx_data;
      start_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (rx_data == CMD_W || rx_data == CMD_R) begin
                  cmd_nxt   = rx_data;
                  state_nxt = ADDR_H;
               end else begin
                  tx_data_nxt = RSP_ERR;
                  state_nxt   = TX_ACK;
               end
            end
         end
         ADDR_H: begin
            if (accept) begin
               addr_nxt[15:8] = rx_data;
               state_nxt      = ADDR_L;
            end
         end
         ADDR_L: begin
            if (accept) begin
               addr_nxt[7:0] = rx_data;
               state_nxt     = LEN;
            end
         end
         LEN: begin
            if (accept) begin
               cnt_nxt   = len_count(rx_data);
               state_nxt = we ? WR_DATA : RD_DATA;
            end
         end
         WR_DATA: begin
            if (accept) begin
               wdata_nxt = rx_data;
               start_nxt = 1'b1;
               state_nxt = BUS_WAIT;
            end
         end
         RD_DATA: begin
            start_nxt = 1'b1;
            state_nxt = BUS_WAIT;
         end
         BUS_WAIT: begin
            if (bus_gnt && bus_req && !we) state_nxt = BUS_ACC;
         end
         BUS_ACC: begin
            if (!bus_gnt) state_nxt = BUS_WAIT;
         end
         TX_BYTE: begin
            if (tx_ready) begin
               if (cnt == 9'd0) begin
                  tx_data_nxt = RSP_OK;
                  state_nxt   = TX_ACK;
               end else begin
                  state_nxt = RD_DATA;
               end
            end
         end
         TX_ACK: begin
            if (tx_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Completion of an access, common to both bus states.
      if ((state == BUS_WAIT || state == BUS_ACC) && done) begin
         addr_nxt = addr + 16'd1;
         cnt_nxt  = cnt - 9'd1;
         if (we) begin
            if (cnt == 9'd1) begin
               tx_data_nxt = RSP_OK;
               state_nxt   = TX_ACK;
            end else begin
               state_nxt = WR_DATA;
            end
         end else begin
            tx_data_nxt = rdata;
            state_nxt   = TX_BYTE;
         end
      end

      if (tmo) begin
         tx_data_nxt = RSP_TMO;
         start_nxt   = 1'b0;
         state_nxt   = TX_ACK;
      end
   end

`ifdef BUS_BRIDGE_TIMEOUT_EN
   logic [31:0] gap;
   logic        waiting;

   assign waiting = state inside {ADDR_H, ADDR_L, LEN, WR_DATA};
   assign tmo     = waiting && !accept &&
                    (gap == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   gap <= 32'd0;
      else if (!waiting || accept) gap <= 32'd0;
      else                       gap <= gap + 32'd1;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
   assign tmo        = 1'b0;
`endif

   bus_bridge_access u_access (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .done    (done),
      .rdata   (rdata),
      .bus_req (bus_req),
      .bus_gnt (bus_gnt),
      .address (address),
      .dout    (dout),
      .din     (din),
      .read    (read)
   );

endmodule
